mlp_stream_loader: RTL and testbench

Input-side stream loader inside `Top` that consumes the host word stream on `data_in` after a `ready` start pulse. It demultiplexes the fixed-order payload (ifmap, then weights, then bias) into a single registered write port addressed per buffer region. On completion it signals the compute core to begin. Geometry is set by `mode`: MLP0 (64-wide) or MLP3 (128-wide).

---
 rtl/mlp_stream_loader.sv | 132 +++++++++++++
 tb/tb_mlp_stream_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mlp_stream_loader.sv
// Host word-stream loader: routes ifmap, weight and bias words to one registered write port.
// Optional byte checksum of the loaded payload when LOADER_CHKSUM_EN is defined.
module mlp_stream_loader #(
    parameter int DATA_SIZE = 32,
    parameter int DIM0      = 64,
    parameter int DIM1      = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 ready,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic                 wr_en,
    output logic [1:0]           wr_sel,
    output logic [11:0]          wr_addr,
    output logic [DATA_SIZE-1:0] wr_data,
    output logic                 busy,
    output logic                 load_done,
    output logic                 mode_q
`ifdef LOADER_CHKSUM_EN
    ,
    output logic [15:0]          chksum
`endif
);

    localparam logic [11:0] VEC0_LAST = 12'(DIM0 / 4 - 1);
    localparam logic [11:0] VEC1_LAST = 12'(DIM1 / 4 - 1);
    localparam logic [11:0] WGT0_LAST = 12'(DIM0 * DIM0 / 4 - 1);
    localparam logic [11:0] WGT1_LAST = 12'(DIM1 * DIM1 / 4 - 1);

    typedef enum logic [1:0] {
        IDLE,
        IFMAP,
        WEIGHT,
        BIAS
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [11:0] cnt_q;
    logic [11:0] cnt_d;
    logic [11:0] limit;
    logic [1:0]  sel;
    logic        active;
    logic        start;
    logic        last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        sel     = 2'd0;
        active  = (state_q != IDLE);
        // Geometry comes from the latched mode, never the live input
        if (state_q == WEIGHT) begin
            limit = mode_q ? WGT1_LAST : WGT0_LAST;
        end else begin
            limit = mode_q ? VEC1_LAST : VEC0_LAST;
        end
        last = active && (cnt_q == limit);
        if (active) begin
            cnt_d = last ? 12'd0 : cnt_q + 12'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (ready) begin
                    start   = 1'b1;
                    cnt_d   = 12'd0;
                    state_d = IFMAP;
                end
            end
            IFMAP: begin
                sel = 2'd0;
                if (last) state_d = WEIGHT;
            end
            WEIGHT: begin
                sel = 2'd1;
                if (last) state_d = BIAS;
            end
            BIAS: begin
                sel = 2'd2;
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 12'd0;
            mode_q    <= 1'b0;
            wr_en     <= 1'b0;
            wr_sel    <= 2'd0;
            wr_addr   <= 12'd0;
            wr_data   <= '0;
            busy      <= 1'b0;
            load_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en     <= active;
            load_done <= last && (state_q == BIAS);
            // Stays high through the final write cycle
            busy      <= active || start;
            if (start) mode_q <= mode;
            if (active) begin
                wr_sel  <= sel;
                wr_addr <= cnt_q;
                wr_data <= data_in;
            end
        end
    end

`ifdef LOADER_CHKSUM_EN
    logic [15:0] byte_sum;

    assign byte_sum = 16'(data_in[7:0]) + 16'(data_in[15:8])
                    + 16'(data_in[23:16]) + 16'(data_in[31:24]);

    always_ff @(posedge clk) begin
        if (rst) begin
            chksum <= 16'd0;
        end else if (start) begin
            chksum <= 16'd0;
        end else if (active) begin
            chksum <= chksum + byte_sum;
        end
    end
`endif

endmodule

// File: tb/tb_mlp_stream_loader.sv
// Directed bench for mlp_stream_loader: full loads in both modes, mid-load ready/reset,
// back-to-back start and (with LOADER_CHKSUM_EN) the byte checksum.
module tb_mlp_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        ready;
    logic [31:0] data_in;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        load_done;
    logic        mode_q;
`ifdef LOADER_CHKSUM_EN
    logic [15:0] chksum;
`endif

    int checks = 0;
    int errors = 0;

    mlp_stream_loader dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .ready     (ready),
        .data_in   (data_in),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .load_done (load_done),
        .mode_q    (mode_q)
`ifdef LOADER_CHKSUM_EN
        ,
        .chksum    (chksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef LOADER_CHKSUM_EN
    function automatic logic [15:0] bsum(input logic [31:0] w);
        return 16'(w[7:0]) + 16'(w[15:8]) + 16'(w[23:16]) + 16'(w[31:24]);
    endfunction
`endif

    task automatic idle_check(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, "_done"}, 64'(load_done), 64'd0);
    endtask

    // rst_at / rdy_at: word index at which to pulse rst / ready (-1 = never)
    task automatic load(input bit m, input int rst_at, input int rdy_at,
                        input bit ones);
        int ifw;
        int wn;
        int n;
        int e_sel;
        int e_addr;
        logic [31:0] v;
        logic [15:0] cs;
        ifw = m ? 32 : 16;
        wn  = m ? 4096 : 1024;
        n   = 2 * ifw + wn;
        cs  = 16'd0;
        mode  = m;
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_wr_en", 64'(wr_en), 64'd0);
        chk("start_done", 64'(load_done), 64'd0);
        chk("start_mode_q", 64'(mode_q), 64'(m));
        data_in = ones ? 32'h0101_0101 : 32'd0;
        for (int k = 0; k < n; k++) begin
            if (k == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                idle_check("rst_mid");
                repeat (3) begin
                    step();
                    idle_check("rst_after");
                end
                return;
            end
            if (k == rdy_at) begin
                ready = 1'b1;
                mode  = ~m;
            end
            v = data_in;
            step();
            ready = 1'b0;
            if (k < ifw) begin
                e_sel  = 0;
                e_addr = k;
            end else if (k < ifw + wn) begin
                e_sel  = 1;
                e_addr = k - ifw;
            end else begin
                e_sel  = 2;
                e_addr = k - ifw - wn;
            end
            chk("wr_en", 64'(wr_en), 64'd1);
            chk("wr_sel", 64'(wr_sel), 64'(e_sel));
            chk("wr_addr", 64'(wr_addr), 64'(e_addr));
            chk("wr_data", 64'(wr_data), 64'(v));
            chk("load_done", 64'(load_done), 64'(k == n - 1));
            chk("busy", 64'(busy), 64'd1);
            chk("mode_q", 64'(mode_q), 64'(m));
`ifdef LOADER_CHKSUM_EN
            cs = cs + bsum(v);
            if (k == n - 1)
                chk("chksum", 64'(chksum), ones ? 64'h1080 : 64'(cs));
`endif
            data_in = ones ? 32'h0101_0101 : 32'(k + 1);
        end
    endtask

    initial begin
        rst     = 1'b1;
        ready   = 1'b0;
        mode    = 1'b0;
        data_in = 32'hDEAD_BEEF;
        step();
        step();
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_sel", 64'(wr_sel), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_mode_q", 64'(mode_q), 64'd0);
`ifdef LOADER_CHKSUM_EN
        chk("rst_chksum", 64'(chksum), 64'd0);
`endif
        rst = 1'b0;
        step();
        idle_check("idle0");

        // rst and ready on the same edge: stay idle, no mode latch
        rst   = 1'b1;
        ready = 1'b1;
        mode  = 1'b1;
        step();
        rst   = 1'b0;
        ready = 1'b0;
        idle_check("rst_rdy");
        chk("rst_rdy_mode_q", 64'(mode_q), 64'd0);
        step();
        idle_check("rst_rdy2");

        load(1'b0, -1, -1, 1'b0);
        step();
        idle_check("m0_end");

        load(1'b1, -1, -1, 1'b0);
        step();
        idle_check("m1_end");
        mode = 1'b0;
        step();
        chk("m1_mode_q_held", 64'(mode_q), 64'd1);

        load(1'b0, -1, 500, 1'b0);
        step();
        idle_check("rdy_mid_end");

        load(1'b0, 16 + 200, -1, 1'b0);

        // restart, then second start sampled at the first idle edge
        load(1'b0, -1, -1, 1'b0);
        load(1'b0, -1, -1, 1'b1);
        step();
        idle_check("b2b_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
